// File: rtl/draw_bg_layers.sv
// draw_bg_layers: background generator placed between vga_timing and the
// sprite/mouse stages. N_RECT programmable rectangles over a flat colour,
// plus screen-edge marker lines. Two-clock pipeline, one pixel per clock.
// The rectangle table is written into a shadow copy and moved to the active
// copy on the rising edge of vblank, so a frame never mixes old and new data.
// Optional feature: define DRAW_BG_BLINK_EN for per-rectangle blinking
// driven by a 6-bit commit counter (32 frames shown, 32 hidden).
module draw_bg_layers #(
  parameter int          N_RECT     = 4,
  parameter int          HOR_PIXELS = 1024,
  parameter int          VER_PIXELS = 768,
  parameter logic [11:0] BG_COLOR   = 12'h000,
  parameter bit          EDGE_EN    = 1'b1,
  localparam int         IW         = (N_RECT > 1) ? $clog2(N_RECT) : 1
) (
  input  logic          clk65MHz,
  input  logic          rst,
  input  logic [10:0]   in_hcount,
  input  logic [10:0]   in_vcount,
  input  logic          in_hsync,
  input  logic          in_hblnk,
  input  logic          in_vsync,
  input  logic          in_vblnk,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [IW-1:0] cfg_idx,
  input  logic [10:0]   cfg_x0,
  input  logic [10:0]   cfg_y0,
  input  logic [10:0]   cfg_x1,
  input  logic [10:0]   cfg_y1,
  input  logic [11:0]   cfg_rgb,
  input  logic          cfg_en,
  input  logic          cfg_blink,
  output logic [10:0]   out_hcount,
  output logic [10:0]   out_vcount,
  output logic          out_hsync,
  output logic          out_hblnk,
  output logic          out_vsync,
  output logic          out_vblnk,
  output logic [11:0]   out_rgb
);

  typedef struct packed {
    logic [10:0] x0;
    logic [10:0] y0;
    logic [10:0] x1;
    logic [10:0] y1;
    logic [11:0] rgb;
    logic        en;
`ifdef DRAW_BG_BLINK_EN
    logic        blink;
`endif
  } rect_t;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        hblnk;
    logic        vsync;
    logic        vblnk;
  } timing_t;

  rect_t             shadow_q [N_RECT];
  rect_t             shadow_d [N_RECT];
  rect_t             active_q [N_RECT];
  rect_t             active_d [N_RECT];
  rect_t             wr_entry;
  logic              vblnk_prev_q;
  logic              commit;
  logic              accept;
  timing_t           tim1_q, tim1_d;
  timing_t           tim2_q, tim2_d;
  logic [N_RECT-1:0] hit1_q, hit1_d;
  logic [11:0]       rgb_q, rgb_d;
  logic [11:0]       rect_rgb;

`ifdef DRAW_BG_BLINK_EN
  logic [5:0]        frame_q, frame_d;
`else
  logic              unused_blink;
  assign unused_blink = cfg_blink;
`endif

  // Commit fires in the cycle in_vblnk rises; config is stalled for that cycle
  // so a table copy and a shadow write never coincide.
  assign commit    = in_vblnk & ~vblnk_prev_q;
  assign cfg_ready = ~rst & ~commit;
  assign accept    = cfg_valid & cfg_ready;

  // Shadow takes handshaken writes; active copies the whole shadow on commit.
  always_comb begin
    wr_entry.x0    = cfg_x0;
    wr_entry.y0    = cfg_y0;
    wr_entry.x1    = cfg_x1;
    wr_entry.y1    = cfg_y1;
    wr_entry.rgb   = cfg_rgb;
    wr_entry.en    = cfg_en;
`ifdef DRAW_BG_BLINK_EN
    wr_entry.blink = cfg_blink;
    frame_d        = commit ? frame_q + 6'd1 : frame_q;
`endif
    shadow_d = shadow_q;
    active_d = active_q;
    if (commit) active_d = shadow_q;
    for (int i = 0; i < N_RECT; i++) begin
      // Indices at or above N_RECT match no entry and are dropped silently.
      if (accept && (cfg_idx == IW'(i))) shadow_d[i] = wr_entry;
    end
  end

  // Table and commit-detect registers.
  always_ff @(posedge clk65MHz) begin
    if (rst) begin
      vblnk_prev_q <= 1'b0;
      for (int i = 0; i < N_RECT; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
`ifdef DRAW_BG_BLINK_EN
      frame_q <= '0;
`endif
    end else begin
      vblnk_prev_q <= in_vblnk;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
`ifdef DRAW_BG_BLINK_EN
      frame_q      <= frame_d;
`endif
    end
  end

  // Stage 1: per-rectangle hit test against the active table.
  always_comb begin
    tim1_d = '{in_hcount, in_vcount, in_hsync, in_hblnk, in_vsync, in_vblnk};
    hit1_d = '0;
    for (int i = 0; i < N_RECT; i++) begin
      // Empty or inverted rectangles fail one of the half-open compares.
      hit1_d[i] = active_q[i].en
                  && (in_hcount >= active_q[i].x0) && (in_hcount < active_q[i].x1)
                  && (in_vcount >= active_q[i].y0) && (in_vcount < active_q[i].y1);
`ifdef DRAW_BG_BLINK_EN
      if (active_q[i].blink && frame_q[5]) hit1_d[i] = 1'b0;
`endif
    end
  end

  // Stage 2: colour priority blank > edge lines > lowest-index rect > BG.
  // active_q may be replaced on the same edge only while stage 1 holds a
  // vblank pixel, so reading rgb here cannot mix two tables.
  always_comb begin
    tim2_d   = tim1_q;
    rect_rgb = BG_COLOR;
    for (int i = N_RECT - 1; i >= 0; i--) begin
      if (hit1_q[i]) rect_rgb = active_q[i].rgb;
    end
    if (tim1_q.hblnk || tim1_q.vblnk)
      rgb_d = 12'h000;
    else if (EDGE_EN && (tim1_q.vcount == 11'd0))
      rgb_d = 12'hff0;
    else if (EDGE_EN && (tim1_q.vcount == 11'(VER_PIXELS - 1)))
      rgb_d = 12'hf00;
    else if (EDGE_EN && (tim1_q.hcount == 11'd0))
      rgb_d = 12'h0f0;
    else if (EDGE_EN && (tim1_q.hcount == 11'(HOR_PIXELS - 1)))
      rgb_d = 12'h00f;
    else
      rgb_d = rect_rgb;
  end

  // Pipeline registers for both stages.
  always_ff @(posedge clk65MHz) begin
    if (rst) begin
      tim1_q <= '0;
      hit1_q <= '0;
      tim2_q <= '0;
      rgb_q  <= '0;
    end else begin
      tim1_q <= tim1_d;
      hit1_q <= hit1_d;
      tim2_q <= tim2_d;
      rgb_q  <= rgb_d;
    end
  end

  assign out_hcount = tim2_q.hcount;
  assign out_vcount = tim2_q.vcount;
  assign out_hsync  = tim2_q.hsync;
  assign out_hblnk  = tim2_q.hblnk;
  assign out_vsync  = tim2_q.vsync;
  assign out_vblnk  = tim2_q.vblnk;
  assign out_rgb    = rgb_q;

endmodule
